// File: rtl/range_sched.sv
// range_sched: round-robin arbiter sharing one 2*W2-bit unit
// among three requesters of widths W, 2*W2 and W2.
module range_sched #(
  parameter int W   = 4,
  parameter int W2  = W + 1,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req1,
  input  logic            req2,
  input  logic            req3,
  input  logic [W-1:0]    in1,
  input  logic [2*W2-1:0] in2,
  input  logic [W2-1:0]   in3,
  output logic [W-1:0]    r1,
  output logic [2*W2-1:0] r2,
  output logic [W2-1:0]   r3,
  output logic            done1,
  output logic            done2,
  output logic            done3,
  output logic [2*W2-1:0] su_in,
  output logic            su_go,
  input  logic [2*W2-1:0] su_out,
  output logic            busy
);

  localparam int SW = 2 * W2;
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] su_in_q, su_in_d;
  logic [W-1:0]  r1_q, r1_d;
  logic [SW-1:0] r2_q, r2_d;
  logic [W2-1:0] r3_q, r3_d;

  logic [2:0] req;
  logic       any_req;
  logic [1:0] pick;

  assign req     = {req3, req2, req1};
  assign any_req = |req;

  // Rotating priority: search starts just after the last grant.
  always_comb begin
    pick = 2'd1;
    case (last_q)
      2'd1:    pick = req[1] ? 2'd2 :
                      req[2] ? 2'd3 : 2'd1;
      2'd2:    pick = req[2] ? 2'd3 :
                      req[0] ? 2'd1 : 2'd2;
      default: pick = req[0] ? 2'd1 :
                      req[1] ? 2'd2 : 2'd3;
    endcase
  end

  // Next-state, grant, counter and result capture.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    su_in_d = su_in_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          last_d  = pick;
          case (pick)
            2'd1:    su_in_d = SW'(in1);
            2'd2:    su_in_d = in2;
            default: su_in_d = SW'(in3);
          endcase
        end
      end
      ISSUE: begin
        cnt_d   = CW'(LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          case (last_q)
            2'd1:    r1_d = su_out[W-1:0];
            2'd2:    r2_d = su_out;
            default: r3_d = su_out[W2-1:0];
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      su_in_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      su_in_q <= su_in_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
    end
  end

  assign su_in = su_in_q;
  assign su_go = (state_q == ISSUE);
  assign busy  = (state_q != IDLE);
  assign done1 = (state_q == DONE) && (last_q == 2'd1);
  assign done2 = (state_q == DONE) && (last_q == 2'd2);
  assign done3 = (state_q == DONE) && (last_q == 2'd3);
  assign r1    = r1_q;
  assign r2    = r2_q;
  assign r3    = r3_q;

endmodule

// File: tb/tb_range_sched.sv
// tb_range_sched: directed + random checks of range_sched
// against a transaction-level rotation/width model.
module tb_range_sched;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req1 = 0, req2 = 0, req3 = 0;
  logic [3:0] in1 = '0;
  logic [9:0] in2 = '0;
  logic [4:0] in3 = '0;
  logic [3:0] r1;
  logic [9:0] r2;
  logic [4:0] r3;
  logic       done1, done2, done3;
  logic [9:0] su_in, su_out;
  logic       su_go, busy;

  logic       b_req3 = 0;
  logic [4:0] b_in3 = '0;
  logic [3:0] b_r1;
  logic [9:0] b_r2;
  logic [4:0] b_r3;
  logic       b_done1, b_done2, b_done3;
  logic [9:0] b_su_in, b_su_out;
  logic       b_su_go, b_busy;

  bit         force_all = 0;
  logic [9:0] xmask = '0;

  int checks = 0;
  int errors = 0;

  int         last_m;
  logic [9:0] rm [1:3];

  always #5 clk = ~clk;

  assign su_out   = force_all ? 10'h3FF : (su_in ^ xmask);
  assign b_su_out = b_su_in;

  range_sched #(.W(4), .W2(5), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req1(req1), .req2(req2), .req3(req3),
    .in1(in1), .in2(in2), .in3(in3),
    .r1(r1), .r2(r2), .r3(r3),
    .done1(done1), .done2(done2), .done3(done3),
    .su_in(su_in), .su_go(su_go),
    .su_out(su_out), .busy(busy)
  );

  range_sched #(.W(4), .W2(5), .LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req1(1'b0), .req2(1'b0), .req3(b_req3),
    .in1(4'h0), .in2(10'h000), .in3(b_in3),
    .r1(b_r1), .r2(b_r2), .r3(b_r3),
    .done1(b_done1), .done2(b_done2), .done3(b_done3),
    .su_in(b_su_in), .su_go(b_su_go),
    .su_out(b_su_out), .busy(b_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_m = 3;
    rm[1] = '0;
    rm[2] = '0;
    rm[3] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req1 = 0; req2 = 0; req3 = 0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_go", su_go, 0);
    chk("rst_su_in", su_in, 0);
    chk("rst_done", {done3, done2, done1}, 0);
    chk("rst_r", {r3, r2, r1}, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // One operation starting in an IDLE cycle; returns the
  // requester whose done pulse was observed.
  task automatic run_op(input logic [2:0] mask,
                        input logic [3:0] a1,
                        input logic [9:0] a2,
                        input logic [4:0] a3,
                        input bit keep,
                        output int who);
    int         w;
    int         k;
    logic [9:0] ext;
    logic [9:0] res;
    req1 = mask[0]; req2 = mask[1]; req3 = mask[2];
    in1 = a1; in2 = a2; in3 = a3;
    chk("c0_busy", busy, 0);
    w = 0;
    for (int j = 1; j <= 3; j++) begin
      k = (last_m + j - 1) % 3 + 1;
      if (w == 0 && mask[k-1]) w = k;
    end
    ext = (w == 1) ? {6'b0, a1} :
          (w == 2) ? a2 : {5'b0, a3};
    last_m = w;
    res = force_all ? 10'h3FF : (ext ^ xmask);
    if (w == 1) rm[1] = res & 10'h00F;
    else if (w == 2) rm[2] = res;
    else rm[3] = res & 10'h01F;
    tick();
    chk("issue_go", su_go, 1);
    chk("issue_su_in", su_in, ext);
    chk("issue_busy", busy, 1);
    chk("issue_done", {done3, done2, done1}, 0);
    if (!keep) begin
      req1 = 0; req2 = 0; req3 = 0;
    end
    in1 = 4'($urandom);
    in2 = 10'($urandom);
    in3 = 5'($urandom);
    for (int i = 0; i < LAT; i++) begin
      tick();
      chk("wait_go", su_go, 0);
      chk("wait_su_in", su_in, ext);
      chk("wait_busy", busy, 1);
      chk("wait_done", {done3, done2, done1}, 0);
    end
    tick();
    chk("done_vec", {done3, done2, done1},
        32'(3'b001 << (w - 1)));
    chk("done_r1", r1, rm[1][3:0]);
    chk("done_r2", r2, rm[2]);
    chk("done_r3", r3, rm[3][4:0]);
    chk("done_su_in", su_in, ext);
    chk("done_go", su_go, 0);
    who = done1 ? 1 : done2 ? 2 : done3 ? 3 : 0;
    tick();
    chk("end_busy", busy, 0);
    chk("end_done", {done3, done2, done1}, 0);
    req1 = 0; req2 = 0; req3 = 0;
  endtask

  initial begin
    int who;
    int fair [4];
    fair = '{1, 2, 1, 2};
    model_reset();
    do_reset();

    // LAT=1 instance: single req3
    chk("l1_busy0", b_busy, 0);
    b_req3 = 1; b_in3 = 5'h15;
    tick();
    chk("l1_go", b_su_go, 1);
    chk("l1_su_in", b_su_in, 10'h015);
    b_req3 = 0;
    tick();
    chk("l1_wait_go", b_su_go, 0);
    chk("l1_wait_done", b_done3, 0);
    tick();
    chk("l1_done3", {b_done3, b_done2, b_done1}, 3'b100);
    chk("l1_r3", b_r3, 5'h15);
    tick();
    chk("l1_idle", b_busy, 0);

    // single request, pass-through unit
    run_op(3'b001, 4'hA, 10'h0, 5'h0, 1'b0, who);
    chk("single_who", who, 1);
    chk("single_r1", r1, 4'hA);

    // simultaneous requests after reset
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      run_op(3'b111, 4'($urandom), 10'($urandom),
             5'($urandom), 1'b1, who);
      chk("simul_order", who, i);
    end

    // truncation with forced all-ones unit output
    force_all = 1;
    run_op(3'b001, 4'($urandom), 10'($urandom),
           5'($urandom), 1'b0, who);
    run_op(3'b010, 4'($urandom), 10'($urandom),
           5'($urandom), 1'b0, who);
    run_op(3'b100, 4'($urandom), 10'($urandom),
           5'($urandom), 1'b0, who);
    chk("trunc_r1", r1, 4'hF);
    chk("trunc_r2", r2, 10'h3FF);
    chk("trunc_r3", r3, 5'h1F);
    force_all = 0;

    // fairness between req1 and req2
    for (int i = 0; i < 4; i++) begin
      xmask = 10'($urandom);
      run_op(3'b011, 4'($urandom), 10'($urandom),
             5'($urandom), 1'b1, who);
      chk("fair_order", who, fair[i]);
    end
    chk("fair_r3", r3, 5'h1F);

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      logic [2:0] m;
      m = 3'($urandom_range(1, 7));
      xmask = 10'($urandom);
      run_op(m, 4'($urandom), 10'($urandom),
             5'($urandom), 1'($urandom), who);
    end

    // reset during WAIT with req2/req3 pending
    req1 = 1; req2 = 1; req3 = 1;
    tick();
    chk("mid_go", su_go, 1);
    tick();
    chk("mid_wait_busy", busy, 1);
    req1 = 0;
    rst = 1;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_done", {done3, done2, done1}, 0);
    chk("mid_r", {r3, r2, r1}, 0);
    rst = 0;
    model_reset();
    run_op(3'b110, 4'($urandom), 10'($urandom),
           5'($urandom), 1'b0, who);
    chk("mid_first_grant", who, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_sched.md
# range_sched

Round-robin scheduler that shares one `subrange`-style datapath unit, 2*W2 bits wide, among three requesters of different widths (W, 2*W2, W2). It sits between the `range` top-level ports and the shared unit. It grants one requester at a time, zero-extends that requester's operand onto the unit's input and pulses a start strobe. It waits a fixed LAT cycles, then returns the result truncated to the requester's width with a one-cycle done pulse.

## Interface
- `W`, 4, width of requester 1 operand/result.
- `W2`, W+1, width of requester 3 operand/result; shared unit width is 2*W2.
- `LAT`, 2, shared unit latency in cycles from `su_go` to valid `su_out`; legal range ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `req1` / `req2` / `req3`  in  1  request levels.
- `in1`  in  W  requester 1 operand.
- `in2`  in  2*W2  requester 2 operand.
- `in3`  in  W2  requester 3 operand.
- `r1`  out  W  requester 1 result.
- `r2`  out  2*W2  requester 2 result.
- `r3`  out  W2  requester 3 result.
- `done1` / `done2` / `done3`  out  1  one-cycle completion pulses.
- `su_in`  out  2*W2  operand to shared unit.
- `su_go`  out  1  one-cycle start strobe to shared unit.
- `su_out`  in  2*W2  shared unit result.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any `req` is high, grant the first requester in rotating order, starting after `last_grant`.
  - On grant: latch the zero-extended operand into `su_in`, set `last_grant` to the granted requester, go to ISSUE.
  - If no `req` is high, stay in IDLE.
- **ISSUE**
  - `su_go`=1 for exactly this cycle.
  - Load the wait counter with LAT; go to WAIT.
- **WAIT**
  - Decrement the counter each cycle; stay for exactly LAT cycles.
  - In the last WAIT cycle, capture `su_out` into the granted requester's result register; go to DONE.
- **DONE**
  - Assert the granted requester's `done` for one cycle; go to IDLE.
- **Requests**
  - `req` is sampled only in IDLE.
  - Dropping `req` after grant does not cancel the operation; `done` still fires.
  - A `req` still high in the IDLE cycle after DONE counts as a new request.
- **Width rules**
  - `su_in` = {zeros, operand}.
  - `r1` = `su_out[W-1:0]`, `r2` = `su_out`, `r3` = `su_out[W2-1:0]`.
  - Upper bits are discarded silently.
- **Result registers**
  - Each `r_k` updates only on its own capture.
  - Each `r_k` holds its value until that requester's next completion.
- `su_in` stays stable from ISSUE through DONE and holds its last value in IDLE.
- **Rotation**
  - After reset `last_grant`=3, so priority order is 1,2,3.
  - After granting k, priority starts at k+1 (wrapping 3→1).
  - Any continuously requesting requester is served within 3 grants.
- **Reset values:** state IDLE, `su_go`=0, `su_in`=0, `r1`/`r2`/`r3`=0, all `done`=0, `busy`=0, `last_grant`=3, counter 0.
- **Reset mid-operation** (any non-IDLE state)
  - Abort: no `done` pulse, no result update, `su_out` ignored.
  - Internal `last_grant` is reset.

## Timing
- `req` high in IDLE at cycle 0:
  - ISSUE/`su_go` at cycle 1.
  - WAIT cycles 2..1+LAT; capture at end of cycle 1+LAT.
  - `done_k` and new `r_k` visible at cycle 2+LAT.
  - IDLE again at cycle 3+LAT.
- Request-to-done latency is 2+LAT cycles.
- Back-to-back grants are 3+LAT cycles apart: 5 cycles for LAT=2.
- `busy` rises at cycle 1 and falls at cycle 3+LAT.
- `su_go` never asserts twice within one operation.

## Test plan
- **Single request:** LAT=2, pass-through unit model, `req1`=1, `in1`=4'hA at cycle 0.
  - Expect `su_go`=1 with `su_in`=10'h00A at cycle 1.
  - Expect `done1`=1 with `r1`=4'hA at cycle 4; `busy` low at cycle 5.
- **Simultaneous requests:** `req1`/`req2`/`req3` all high from cycle 0 after reset.
  - Expect `done1` at cycle 4, `done2` at cycle 9, `done3` at cycle 14.
  - Expect only one `done` high per cycle.
- **Truncation:** unit model forces `su_out`=10'h3FF.
  - Expect `r1`=4'hF, `r2`=10'h3FF, `r3`=5'h1F after the respective completions.
  - Other results unchanged.
- **Fairness:** `req1` and `req2` held high continuously for 4 grants.
  - Expect grant order 1,2,1,2.
  - Expect `r3`/`done3` untouched.
- **Reset mid-op:** `rst` asserted during WAIT with `req2` and `req3` pending.
  - Expect no `done` pulse and `busy`=0 the next cycle.
  - After `rst` drops, expect first grant to requester 2.
- **LAT=1 build:** single `req3`, `in3`=5'h15.
  - Expect `su_go` at cycle 1 and `done3` with `r3`=5'h15 at cycle 3.
